// File: rtl/v3a_queue_op_issuer.sv
// v3a_queue_op_issuer: single-outstanding command initiator for the v3a
// double-ended tagged queue. Keeps a shadow occupancy count, pre-rejects
// overflow/underflow and illegal opcodes, and bounds every queue wait.
module v3a_queue_op_issuer #(
  parameter int unsigned p_depth     = 32,
  parameter int unsigned p_ptrwidth  = $clog2(p_depth),
  parameter int unsigned p_chanwidth = 32,
  parameter int unsigned p_timeout   = 2 * p_depth + 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_val,
  output logic                   cmd_rdy,
  input  logic [2:0]             cmd_op,
  input  logic [p_ptrwidth-1:0]  cmd_tag,
  input  logic [p_chanwidth-1:0] cmd_data,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic [2:0]             resp_op,
  output logic                   resp_err,
  output logic [p_ptrwidth-1:0]  resp_tag,
  output logic [p_chanwidth-1:0] resp_data,
  output logic [p_ptrwidth:0]    occ_count,
  output logic                   enq_back_en,
  output logic                   enq_front_en,
  output logic                   deq_front_en,
  output logic                   deq_back_en,
  output logic                   upd_en,
  output logic                   del_en,
  input  logic                   enq_back_cpl,
  input  logic                   enq_front_cpl,
  input  logic                   deq_front_cpl,
  input  logic                   deq_back_cpl,
  input  logic                   upd_cpl,
  input  logic                   del_cpl,
  input  logic [p_ptrwidth-1:0]  enq_back_tag_out,
  input  logic [p_ptrwidth-1:0]  enq_front_tag_out,
  input  logic [p_chanwidth-1:0] deq_front_data,
  input  logic [p_chanwidth-1:0] deq_back_data,
  output logic [p_chanwidth-1:0] enq_back_data,
  output logic [p_chanwidth-1:0] enq_front_data,
  output logic [p_chanwidth-1:0] upd_data_in,
  output logic [p_ptrwidth-1:0]  upd_tag_in,
  output logic [p_ptrwidth-1:0]  del_tag_in
);

  localparam int unsigned occ_w = p_ptrwidth + 1;
  localparam int unsigned cnt_w = $clog2(p_timeout + 1);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_wait = 2'd1;
  localparam logic [1:0] st_resp = 2'd2;

  localparam logic [2:0] op_enq_back  = 3'd0;
  localparam logic [2:0] op_enq_front = 3'd1;
  localparam logic [2:0] op_deq_front = 3'd2;
  localparam logic [2:0] op_deq_back  = 3'd3;
  localparam logic [2:0] op_upd       = 3'd4;
  localparam logic [2:0] op_del       = 3'd5;

  logic [1:0]             state_q, state_d;
  logic [cnt_w-1:0]       cnt_q, cnt_d;
  logic [occ_w-1:0]       occ_q, occ_d;
  logic [2:0]             op_q, op_d;
  logic [p_ptrwidth-1:0]  tag_q, tag_d;
  logic [p_chanwidth-1:0] data_q, data_d;
  logic                   err_q, err_d;
  logic [p_ptrwidth-1:0]  rtag_q, rtag_d;
  logic [p_chanwidth-1:0] rdata_q, rdata_d;

  logic own_cpl;
  logic wait_fire;
  logic cmd_is_enq, cmd_is_ill, cmd_rej, cmd_has_tag;

  // Completion of the op currently in flight; all other cpl lines are ignored
  always_comb begin
    own_cpl = 1'b0;
    case (op_q)
      op_enq_back:  own_cpl = enq_back_cpl;
      op_enq_front: own_cpl = enq_front_cpl;
      op_deq_front: own_cpl = deq_front_cpl;
      op_deq_back:  own_cpl = deq_back_cpl;
      op_upd:       own_cpl = upd_cpl;
      op_del:       own_cpl = del_cpl;
      default:      own_cpl = 1'b0;
    endcase
  end

  // Local admission check on the incoming command
  always_comb begin
    cmd_is_ill  = (cmd_op > op_del);
    cmd_is_enq  = (cmd_op == op_enq_back) || (cmd_op == op_enq_front);
    cmd_has_tag = (cmd_op == op_upd) || (cmd_op == op_del);
    cmd_rej     = cmd_is_ill
                || (cmd_is_enq && (occ_q == occ_w'(p_depth)))
                || (!cmd_is_enq && (occ_q == '0));
  end

  // Next-state and response capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    occ_d   = occ_q;
    op_d    = op_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
    rtag_d  = rtag_q;
    rdata_d = rdata_q;
    case (state_q)
      st_idle: begin
        if (cmd_val) begin
          op_d    = cmd_op;
          tag_d   = cmd_tag;
          data_d  = cmd_data;
          rdata_d = '0;
          rtag_d  = cmd_has_tag ? cmd_tag : '0;
          if (cmd_rej) begin
            err_d   = 1'b1;
            state_d = st_resp;
          end else begin
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = st_wait;
          end
        end
      end
      st_wait: begin
        if (own_cpl) begin
          err_d   = 1'b0;
          state_d = st_resp;
          case (op_q)
            op_enq_back: begin
              rtag_d = enq_back_tag_out;
              occ_d  = occ_q + occ_w'(1);
            end
            op_enq_front: begin
              rtag_d = enq_front_tag_out;
              occ_d  = occ_q + occ_w'(1);
            end
            op_deq_front: begin
              rtag_d  = '0;
              rdata_d = deq_front_data;
              occ_d   = occ_q - occ_w'(1);
            end
            op_deq_back: begin
              rtag_d  = '0;
              rdata_d = deq_back_data;
              occ_d   = occ_q - occ_w'(1);
            end
            op_del:  occ_d = occ_q - occ_w'(1);
            default: occ_d = occ_q;
          endcase
        end else if (cnt_q == cnt_w'(p_timeout - 1)) begin
          err_d   = 1'b1;
          state_d = st_resp;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      st_resp: begin
        if (resp_rdy) state_d = st_idle;
      end
      default: state_d = st_idle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= st_idle;
      cnt_q   <= '0;
      occ_q   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      rtag_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
      rtag_q  <= rtag_d;
      rdata_q <= rdata_d;
    end
  end

  // Enable is masked by own_cpl so the queue never sees a re-fire in the cpl cycle
  always_comb begin
    wait_fire    = (state_q == st_wait) && !own_cpl;
    enq_back_en  = wait_fire && (op_q == op_enq_back);
    enq_front_en = wait_fire && (op_q == op_enq_front);
    deq_front_en = wait_fire && (op_q == op_deq_front);
    deq_back_en  = wait_fire && (op_q == op_deq_back);
    upd_en       = wait_fire && (op_q == op_upd);
    del_en       = wait_fire && (op_q == op_del);
  end

  assign cmd_rdy        = (state_q == st_idle);
  assign resp_val       = (state_q == st_resp);
  assign resp_op        = op_q;
  assign resp_err       = err_q;
  assign resp_tag       = rtag_q;
  assign resp_data      = rdata_q;
  assign occ_count      = occ_q;
  assign enq_back_data  = data_q;
  assign enq_front_data = data_q;
  assign upd_data_in    = data_q;
  assign upd_tag_in     = tag_q;
  assign del_tag_in     = tag_q;

endmodule

// File: tb/tb_v3a_queue_op_issuer.sv
// Bench for v3a_queue_op_issuer: a behavioural deque stands in for the queue
// controller and predicts every response, occupancy and enable pattern.
`timescale 1ns/1ps
module tb_v3a_queue_op_issuer;

  localparam int DEPTH = 32;
  localparam int TMO   = 2 * DEPTH + 8;

  logic clk = 1'b0;
  logic rst;
  logic cmd_val, cmd_rdy, resp_val, resp_rdy, resp_err;
  logic [2:0] cmd_op, resp_op;
  logic [4:0] cmd_tag, resp_tag;
  logic [31:0] cmd_data, resp_data;
  logic [5:0] occ_count;
  logic enq_back_en, enq_front_en, deq_front_en, deq_back_en, upd_en, del_en;
  logic [5:0] cpl_vec;
  logic [4:0] enq_back_tag_out, enq_front_tag_out, upd_tag_in, del_tag_in;
  logic [31:0] deq_front_data, deq_back_data, enq_back_data, enq_front_data, upd_data_in;
  logic [5:0] en_vec;

  typedef struct packed { logic [4:0] tag; logic [31:0] data; } ent_t;
  ent_t mq[$];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign en_vec = {del_en, upd_en, deq_back_en, deq_front_en, enq_front_en, enq_back_en};

  v3a_queue_op_issuer dut (
    .clk(clk), .rst(rst),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_tag(cmd_tag), .cmd_data(cmd_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_op(resp_op), .resp_err(resp_err),
    .resp_tag(resp_tag), .resp_data(resp_data), .occ_count(occ_count),
    .enq_back_en(enq_back_en), .enq_front_en(enq_front_en), .deq_front_en(deq_front_en),
    .deq_back_en(deq_back_en), .upd_en(upd_en), .del_en(del_en),
    .enq_back_cpl(cpl_vec[0]), .enq_front_cpl(cpl_vec[1]), .deq_front_cpl(cpl_vec[2]),
    .deq_back_cpl(cpl_vec[3]), .upd_cpl(cpl_vec[4]), .del_cpl(cpl_vec[5]),
    .enq_back_tag_out(enq_back_tag_out), .enq_front_tag_out(enq_front_tag_out),
    .deq_front_data(deq_front_data), .deq_back_data(deq_back_data),
    .enq_back_data(enq_back_data), .enq_front_data(enq_front_data), .upd_data_in(upd_data_in),
    .upd_tag_in(upd_tag_in), .del_tag_in(del_tag_in)
  );

  function automatic int find_tag(input logic [4:0] t);
    for (int i = 0; i < mq.size(); i++) if (mq[i].tag == t) return i;
    return -1;
  endfunction

  // One full command: admission, queue emulation with latency lat, response, handshake
  task automatic issue(input logic [2:0] op, input logic [4:0] tg, input logic [31:0] dat,
                       input int lat, input bit never, input logic [4:0] rtag);
    bit illegal, is_enq, rej, exp_err;
    int lat_eff, exp_c, got_c, idx, en_bad, op_bad, hold;
    logic [5:0] own, exp_en;
    logic [31:0] exp_data;
    logic [4:0] exp_tag;
    logic [2:0] s_op; logic s_err; logic [4:0] s_tag; logic [31:0] s_data;
    bit unstable;
    ent_t e;
    illegal = (op >= 3'd6);
    is_enq  = (op <= 3'd1);
    rej     = illegal || (is_enq && mq.size() == DEPTH) || (!is_enq && !illegal && mq.size() == 0);
    exp_err = rej || never;
    own     = illegal ? 6'd0 : (6'd1 << op);
    lat_eff = never ? TMO : lat;
    exp_c   = rej ? 1 : (never ? TMO + 1 : lat + 2);
    enq_back_tag_out  = rtag;
    enq_front_tag_out = rtag;
    deq_front_data = (mq.size() > 0) ? mq[0].data : $urandom;
    deq_back_data  = (mq.size() > 0) ? mq[mq.size()-1].data : $urandom;
    exp_data = '0;
    exp_tag  = '0;
    if (!exp_err) begin
      case (op)
        3'd0: begin exp_tag = rtag; e = {rtag, dat}; mq.push_back(e); end
        3'd1: begin exp_tag = rtag; e = {rtag, dat}; mq.push_front(e); end
        3'd2: begin exp_data = mq[0].data; void'(mq.pop_front()); end
        3'd3: begin exp_data = mq[mq.size()-1].data; void'(mq.pop_back()); end
        3'd4: begin exp_tag = tg; idx = find_tag(tg);
                if (idx >= 0) begin e = mq[idx]; e.data = dat; mq[idx] = e; end end
        default: begin exp_tag = tg; idx = find_tag(tg); if (idx >= 0) mq.delete(idx); end
      endcase
    end

    @(negedge clk);
    cpl_vec = '0;
    cmd_val = 1'b1; cmd_op = op; cmd_tag = tg; cmd_data = dat;
    #1;
    tests_run++;
    if (cmd_rdy !== 1'b1) begin tests_failed++; $display("FAIL cmd_rdy_idle op=%0d got=%b exp=1", op, cmd_rdy); end

    @(negedge clk);
    cmd_val = 1'b0; cmd_op = 3'($urandom); cmd_tag = 5'($urandom); cmd_data = $urandom;
    got_c = -1; en_bad = 0; op_bad = 0;
    for (int c = 1; c <= 200; c++) begin
      cpl_vec = (6'($urandom) & ~own) | ((!never && c == lat + 1) ? own : 6'd0);
      if (c == exp_c) cpl_vec = 6'($urandom);
      #1;
      exp_en = (!rej && c <= lat_eff) ? own : 6'd0;
      if (en_vec !== exp_en) en_bad++;
      if (en_vec != 6'd0 && (enq_back_data !== dat || enq_front_data !== dat || upd_data_in !== dat ||
                             upd_tag_in !== tg || del_tag_in !== tg)) op_bad++;
      if (resp_val === 1'b1) begin got_c = c; break; end
      @(negedge clk);
    end

    tests_run++;
    if (got_c != exp_c) begin tests_failed++; $display("FAIL resp_latency op=%0d got=%0d exp=%0d", op, got_c, exp_c); end
    tests_run++;
    if (en_bad != 0) begin tests_failed++; $display("FAIL en_pattern op=%0d bad_cycles=%0d exp=0", op, en_bad); end
    tests_run++;
    if (op_bad != 0) begin tests_failed++; $display("FAIL operands op=%0d bad_cycles=%0d exp=0", op, op_bad); end
    tests_run++;
    if (resp_err !== exp_err) begin tests_failed++; $display("FAIL resp_err op=%0d got=%b exp=%b", op, resp_err, exp_err); end
    tests_run++;
    if (resp_op !== op) begin tests_failed++; $display("FAIL resp_op got=%0d exp=%0d", resp_op, op); end
    tests_run++;
    if (resp_data !== exp_data) begin tests_failed++; $display("FAIL resp_data op=%0d got=%h exp=%h", op, resp_data, exp_data); end
    if (!exp_err) begin
      tests_run++;
      if (resp_tag !== exp_tag) begin tests_failed++; $display("FAIL resp_tag op=%0d got=%0d exp=%0d", op, resp_tag, exp_tag); end
    end
    tests_run++;
    if (occ_count !== 6'(mq.size())) begin tests_failed++; $display("FAIL occ_count op=%0d got=%0d exp=%0d", op, occ_count, mq.size()); end

    s_op = resp_op; s_err = resp_err; s_tag = resp_tag; s_data = resp_data;
    unstable = 1'b0;
    hold = $urandom_range(0, 2);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      cpl_vec = 6'($urandom);
      #1;
      if (resp_val !== 1'b1 || cmd_rdy !== 1'b0 || resp_op !== s_op || resp_err !== s_err ||
          resp_tag !== s_tag || resp_data !== s_data || en_vec !== 6'd0) unstable = 1'b1;
    end
    tests_run++;
    if (unstable) begin tests_failed++; $display("FAIL resp_stable op=%0d got=unstable exp=stable", op); end

    @(negedge clk);
    cpl_vec = '0;
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    #1;
    tests_run++;
    if (resp_val !== 1'b0 || cmd_rdy !== 1'b1) begin
      tests_failed++; $display("FAIL resp_release got val=%b rdy=%b exp val=0 rdy=1", resp_val, cmd_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_val = 1'b0; cmd_op = '0; cmd_tag = '0; cmd_data = '0; resp_rdy = 1'b0;
    cpl_vec = '0; enq_back_tag_out = '0; enq_front_tag_out = '0; deq_front_data = '0; deq_back_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (cmd_rdy !== 1'b1 || resp_val !== 1'b0 || occ_count !== 6'd0 || en_vec !== 6'd0 ||
        resp_err !== 1'b0 || resp_tag !== 5'd0 || resp_data !== 32'd0 || resp_op !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state got rdy=%b val=%b occ=%0d en=%b err=%b tag=%0d data=%h op=%0d exp 1 0 0 0 0 0 0 0",
               cmd_rdy, resp_val, occ_count, en_vec, resp_err, resp_tag, resp_data, resp_op);
    end
    mq.delete();
  endtask

  task automatic test_enq_deq_basic();
    issue(3'd0, 5'd0, 32'hA5, 1, 1'b0, 5'd3);
    issue(3'd2, 5'd0, 32'h0, 1, 1'b0, 5'd0);
  endtask

  task automatic test_underflow();
    issue(3'd3, 5'd0, 32'h0, 1, 1'b0, 5'd0);
    issue(3'd4, 5'd2, 32'h55, 1, 1'b0, 5'd0);
    issue(3'd6, 5'd0, 32'h0, 1, 1'b0, 5'd0);
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++)
      issue(3'($urandom_range(0, 1)), 5'd0, $urandom, $urandom_range(1, 3), 1'b0, 5'(i));
    issue(3'd1, 5'd0, 32'hDEAD, 1, 1'b0, 5'd9);
    issue(3'd7, 5'd0, 32'h0, 1, 1'b0, 5'd0);
  endtask

  task automatic test_upd_del();
    issue(3'd4, 5'd5, 32'h1234, 12, 1'b0, 5'd0);
    issue(3'd5, 5'd5, 32'h0, 4, 1'b0, 5'd0);
  endtask

  task automatic test_timeout();
    issue(3'd0, 5'd0, 32'hBEEF, 1, 1'b1, 5'd7);
    issue(3'd2, 5'd0, 32'h0, 2, 1'b0, 5'd0);
  endtask

  task automatic test_random_mix();
    logic [2:0] op; logic [4:0] tg;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      tg = (mq.size() > 0) ? mq[$urandom_range(0, mq.size()-1)].tag : 5'($urandom);
      issue(op, tg, $urandom, $urandom_range(1, 20), 1'b0, 5'($urandom));
    end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    @(negedge clk);
    cmd_val = 1'b1; cmd_op = 3'd0; cmd_data = 32'h77; cmd_tag = '0; cpl_vec = '0;
    @(negedge clk);
    cmd_val = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (enq_back_en !== 1'b1) begin tests_failed++; $display("FAIL midwait_en got=%b exp=1", enq_back_en); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (en_vec !== 6'd0 || cmd_rdy !== 1'b1 || occ_count !== 6'd0 || resp_val !== 1'b0) begin
      tests_failed++;
      $display("FAIL midwait_reset got en=%b rdy=%b occ=%0d val=%b exp 0 1 0 0", en_vec, cmd_rdy, occ_count, resp_val);
    end
    cpl_vec = 6'b000001;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cpl_vec = '0;
      #1;
      if (resp_val !== 1'b0 || occ_count !== 6'd0 || cmd_rdy !== 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin tests_failed++; $display("FAIL late_cpl got=reacted exp=ignored occ=%0d", occ_count); end
    mq.delete();
    issue(3'd1, 5'd0, 32'hC0FFEE, 2, 1'b0, 5'd11);
  endtask

  initial begin
    test_reset();
    test_enq_deq_basic();
    test_underflow();
    test_fill_overflow();
    test_upd_del();
    test_timeout();
    test_random_mix();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
